wb_arbiter_2m: RTL and testbench
================================

Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone arbiter that shares one external bus between the instruction-fetch master (M0) and the data-memory master (M1) of the five-stage CPU.
- Sits between the CPU's fetch and data Wishbone master ports and the single SRAM/peripheral interconnect.
- Grants the bus for a whole Wishbone cycle (CYC high) and forwards the winner's signals to the slave. The loser sees no ACK and stalls through its existing ack-wait logic.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; SEL width is DATA_WIDTH/8.

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-low reset: sampled on the rising edge of clk, and reset==0 resets the block.
- m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i  in  1 each  fetch master control.
- m0_wb_adr_i  in  ADDR_WIDTH  fetch address.
- m0_wb_dat_i  in  DATA_WIDTH  fetch write data.
- m0_wb_sel_i  in  DATA_WIDTH/8  fetch byte select.
- m0_wb_ack_o  out  1  fetch ack.
- m0_wb_dat_o  out  DATA_WIDTH  fetch read data.
- m1_wb_*  same set as m0  data master.
- s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  out  1 each  slave control.
- s_wb_adr_o  out  ADDR_WIDTH  slave address.
- s_wb_dat_o  out  DATA_WIDTH  slave write data.
- s_wb_sel_o  out  DATA_WIDTH/8  slave byte select.
- s_wb_ack_i  in  1  slave ack.
- s_wb_dat_i  in  DATA_WIDTH  slave read data.
- gnt_o  out  2  one-hot grant state: 01 = M0, 10 = M1, 00 = idle.

Behaviour:
- Grant state is registered. States: IDLE, GNT_M0, GNT_M1.
- Reset (reset==0 at an edge): state goes to IDLE and gnt_o=00. All s_wb_* outputs are 0 while in IDLE. m0/m1 ack_o are 0.
- IDLE:
  - If any m*_wb_cyc_i is high, arbitrate and go to the winner's GNT state at the next edge.
  - A request sampled in IDLE produces s_wb_cyc_o one cycle later (1-cycle arbitration latency).
- GNT_Mx:
  - Slave outputs = Mx inputs combinationally (cyc, stb, we, adr, dat, sel).
  - mx_wb_ack_o = s_wb_ack_i and mx_wb_dat_o = s_wb_dat_i.
  - Non-granted master: ack_o = 0 and dat_o = s_wb_dat_i (don't-care).
- Grant is held while mx_wb_cyc_i stays high, regardless of STB gaps. This allows multi-beat cycles without preemption.
- Release: the edge at which the granted master's cyc_i is sampled low re-arbitrates immediately.
  - If the other master requests, go directly to its GNT state (no IDLE bubble).
  - Otherwise go to IDLE.
- Fixed priority (default): M1 beats M0 on a simultaneous request, since data access must drain before fetch for pipeline progress.
- Simultaneous ack and cyc drop from the granted master in the same cycle: the ack is delivered and release happens at that edge.
- Reset mid-cycle:
  - Grant is dropped and s_wb_cyc_o goes to 0 next cycle.
  - An in-flight slave ack arriving after reset is ignored (IDLE routes no ack).
- No timeout. A slave that never acks holds the grant indefinitely, matching the existing masters' behaviour.
- The arbiter never asserts s_wb_stb_o without s_wb_cyc_o.

Optional Feature:
- WB_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last_gnt register is reset to M0.
  - On a simultaneous request, the master not granted last wins; last_gnt updates on every grant.
- Not defined: fixed priority M1 > M0. last_gnt is not instantiated.

Decomposition:
- Shared package wb_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, GNT_M0, GNT_M1}.
  - Constants GNT_NONE=2'b00, GNT_M0_OH=2'b01, GNT_M1_OH=2'b10.
- One sub-module is natural: wb_arb_pick.
  - Combinational pick of the next grant from {req0, req1, last_gnt}.
  - Shared by the IDLE and release paths, and by the RR/fixed variants.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with both cyc high → gnt_o=00, s_wb_cyc_o=0, both ack_o=0. Release reset → gnt_o=10 after 1 edge (fixed priority).
2. Single fetch: M0 reads 0x8000_0000; slave acks 2 cycles later with 0x0000_0013 → m0_wb_dat_o=0x13, m0_wb_ack_o for 1 cycle, m1_wb_ack_o=0 throughout.
3. Contention: M0 and M1 request at the same edge, M1 stores 0xDEADBEEF to 0x8040_0000 with sel=4'hF → M1 served first, slave sees that adr/dat/we=1. After M1 drops cyc, gnt_o goes 10→01 with no IDLE cycle.
4. Held grant: M1 holds cyc for 2 beats with stb low between them while M0 requests → gnt_o stays 10 until M1 cyc=0, and M0 receives no ack in that window.
5. Mid-cycle reset: reset=0 while GNT_M0 and the slave acks on that same cycle → next cycle s_wb_cyc_o=0, gnt_o=00, and m0_wb_ack_o is not asserted after the reset edge.
6. WB_ARB_RR_EN: both masters request continuously, each with 1-cycle transactions → grants alternate M1, M0, M1, M0 (gnt_o 10,01,10,01). Without the macro, M1 retains the grant every time.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and grant encodings for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_M0 = 2'b01,
    GNT_M1 = 2'b10
  } arb_state_t;

  localparam logic [1:0] GNT_NONE  = 2'b00;
  localparam logic [1:0] GNT_M0_OH = 2'b01;
  localparam logic [1:0] GNT_M1_OH = 2'b10;

  function automatic logic [1:0] state_to_gnt(input arb_state_t s);
    logic [1:0] g;
    g = GNT_NONE;
    case (s)
      GNT_M0:  g = GNT_M0_OH;
      GNT_M1:  g = GNT_M1_OH;
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational winner selection from the two CYC requests.
// last_gnt_i: 0 = M0 was granted last, 1 = M1 was granted last.
import wb_arb_pkg::*;

module wb_arb_pick #(
  parameter bit RR_EN = 1'b0
) (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_gnt_i,
  output arb_state_t pick_o
);

  always_comb begin
    pick_o = IDLE;
    if (req0_i && req1_i) begin
      // Round-robin favours whoever was not granted last; fixed mode drains data first.
      if (RR_EN) pick_o = last_gnt_i ? GNT_M0 : GNT_M1;
      else       pick_o = GNT_M1;
    end else if (req1_i) begin
      pick_o = GNT_M1;
    end else if (req0_i) begin
      pick_o = GNT_M0;
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone arbiter; grant held for a whole CYC.
// Define WB_ARB_RR_EN for round-robin arbitration (default: fixed M1 > M0).
import wb_arb_pkg::*;

module wb_arbiter_2m #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    m0_wb_cyc_i,
  input  logic                    m0_wb_stb_i,
  input  logic                    m0_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i,
  output logic                    m0_wb_ack_o,
  output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,

  input  logic                    m1_wb_cyc_i,
  input  logic                    m1_wb_stb_i,
  input  logic                    m1_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i,
  output logic                    m1_wb_ack_o,
  output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,

  output logic                    s_wb_cyc_o,
  output logic                    s_wb_stb_o,
  output logic                    s_wb_we_o,
  output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
  output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_wb_sel_o,
  input  logic                    s_wb_ack_i,
  input  logic [DATA_WIDTH-1:0]   s_wb_dat_i,

  output logic [1:0]              gnt_o
);

  arb_state_t state_q, state_d, pick;
  logic [1:0] gnt_q;
  logic       last_gnt;

`ifdef WB_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
  logic last_gnt_q;
  assign last_gnt = last_gnt_q;
`else
  localparam bit RR_EN = 1'b0;
  assign last_gnt = 1'b0;
`endif

  wb_arb_pick #(.RR_EN(RR_EN)) u_pick (
    .req0_i     (m0_wb_cyc_i),
    .req1_i     (m1_wb_cyc_i),
    .last_gnt_i (last_gnt),
    .pick_o     (pick)
  );

  // On release the owner's own CYC is already low, so the same pick covers
  // both the IDLE path and the direct hand-over to the other master.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = pick;
      GNT_M0:  if (!m0_wb_cyc_i) state_d = pick;
      GNT_M1:  if (!m1_wb_cyc_i) state_d = pick;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= GNT_NONE;
    end else begin
      state_q <= state_d;
      gnt_q   <= state_to_gnt(state_d);
    end
  end

`ifdef WB_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!reset)                last_gnt_q <= 1'b0;
    else if (state_d != IDLE)  last_gnt_q <= (state_d == GNT_M1);
  end
`endif

  assign gnt_o = gnt_q;

  // Read data fans out to both masters; only the ACK is steered.
  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;

  always_comb begin
    s_wb_cyc_o  = 1'b0;
    s_wb_stb_o  = 1'b0;
    s_wb_we_o   = 1'b0;
    s_wb_adr_o  = '0;
    s_wb_dat_o  = '0;
    s_wb_sel_o  = '0;
    m0_wb_ack_o = 1'b0;
    m1_wb_ack_o = 1'b0;
    case (state_q)
      GNT_M0: begin
        s_wb_cyc_o  = m0_wb_cyc_i;
        s_wb_stb_o  = m0_wb_stb_i & m0_wb_cyc_i;
        s_wb_we_o   = m0_wb_we_i;
        s_wb_adr_o  = m0_wb_adr_i;
        s_wb_dat_o  = m0_wb_dat_i;
        s_wb_sel_o  = m0_wb_sel_i;
        m0_wb_ack_o = s_wb_ack_i;
      end
      GNT_M1: begin
        s_wb_cyc_o  = m1_wb_cyc_i;
        s_wb_stb_o  = m1_wb_stb_i & m1_wb_cyc_i;
        s_wb_we_o   = m1_wb_we_i;
        s_wb_adr_o  = m1_wb_adr_i;
        s_wb_dat_o  = m1_wb_dat_i;
        s_wb_sel_o  = m1_wb_sel_i;
        m1_wb_ack_o = s_wb_ack_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: directed scenarios plus random traffic
// compared every cycle against an ownership-based reference model.
module tb_wb_arbiter_2m;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_cyc, m0_stb, m0_we, m0_ack;
  logic [31:0] m0_adr, m0_wdat, m0_rdat;
  logic [3:0]  m0_sel;
  logic        m1_cyc, m1_stb, m1_we, m1_ack;
  logic [31:0] m1_adr, m1_wdat, m1_rdat;
  logic [3:0]  m1_sel;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic [1:0]  gnt;

  int errors = 0;
  int checks = 0;
  int owner  = 0;  // 0 = nobody, 1 = M0, 2 = M1
  int last   = 0;  // 0 = M0 granted last, 1 = M1 granted last
  bit model_valid = 1'b0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_wdat), .m0_wb_sel_i(m0_sel),
    .m0_wb_ack_o(m0_ack), .m0_wb_dat_o(m0_rdat),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_wdat), .m1_wb_sel_i(m1_sel),
    .m1_wb_ack_o(m1_ack), .m1_wb_dat_o(m1_rdat),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
    .s_wb_adr_o(s_adr), .s_wb_dat_o(s_wdat), .s_wb_sel_o(s_sel),
    .s_wb_ack_i(s_ack), .s_wb_dat_i(s_rdat),
    .gnt_o(gnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bus view derived from who owns the bus right now.
  task automatic check_model();
    logic [1:0] eg;
    eg = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
    chk("gnt", gnt, eg);
    if (owner == 1) begin
      chk("s_cyc", s_cyc, m0_cyc);  chk("s_stb", s_stb, m0_stb);
      chk("s_we", s_we, m0_we);     chk("s_adr", s_adr, m0_adr);
      chk("s_dat", s_wdat, m0_wdat); chk("s_sel", s_sel, m0_sel);
      chk("m0_ack", m0_ack, s_ack); chk("m1_ack", m1_ack, 1'b0);
      chk("m0_rdat", m0_rdat, s_rdat);
    end else if (owner == 2) begin
      chk("s_cyc", s_cyc, m1_cyc);  chk("s_stb", s_stb, m1_stb);
      chk("s_we", s_we, m1_we);     chk("s_adr", s_adr, m1_adr);
      chk("s_dat", s_wdat, m1_wdat); chk("s_sel", s_sel, m1_sel);
      chk("m0_ack", m0_ack, 1'b0);  chk("m1_ack", m1_ack, s_ack);
      chk("m1_rdat", m1_rdat, s_rdat);
    end else begin
      chk("idle_bus", {s_cyc, s_stb, s_we, s_sel, s_adr}, 64'd0);
      chk("idle_sdat", s_wdat, 32'd0);
      chk("idle_acks", {m0_ack, m1_ack}, 2'b00);
    end
  endtask

  task automatic model_step();
    if (!reset) begin
      owner = 0;
      last  = 0;
      model_valid = 1'b1;
    end else if (!((owner == 1 && m0_cyc) || (owner == 2 && m1_cyc))) begin
      if (m0_cyc && m1_cyc) begin
`ifdef WB_ARB_RR_EN
        owner = (last == 1) ? 1 : 2;
`else
        owner = 2;
`endif
      end else if (m1_cyc) owner = 2;
      else if (m0_cyc)     owner = 1;
      else                 owner = 0;
      if (owner != 0) last = (owner == 2) ? 1 : 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (model_valid) check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_m0(input logic c, input logic s, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] se);
    m0_cyc = c; m0_stb = s; m0_we = w; m0_adr = a; m0_wdat = d; m0_sel = se;
  endtask

  task automatic set_m1(input logic c, input logic s, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] se);
    m1_cyc = c; m1_stb = s; m1_we = w; m1_adr = a; m1_wdat = d; m1_sel = se;
  endtask

  initial begin
    reset = 1'b0; s_ack = 1'b0; s_rdat = '0;
    set_m0(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    set_m1(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);

    // 1: reset held with both requesting, then fixed-priority first grant
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_scyc", s_cyc, 1'b0);
      chk("rst_acks", {m0_ack, m1_ack}, 2'b00);
    end
    reset = 1'b1;
    cycle();
`ifdef WB_ARB_RR_EN
    chk("rst_release_gnt", gnt, 2'b10);
`else
    chk("rst_release_gnt", gnt, 2'b10);
`endif
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    chk("back_to_idle", gnt, 2'b00);

    // 2: single fetch with 2-cycle slave latency
    set_m0(1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
    cycle();
    chk("fetch_gnt", gnt, 2'b01);
    chk("fetch_sadr", s_adr, 32'h8000_0000);
    cycle(); cycle();
    s_ack = 1'b1; s_rdat = 32'h0000_0013;
    #1;
    chk("fetch_ack", m0_ack, 1'b1);
    chk("fetch_data", m0_rdat, 32'h0000_0013);
    cycle();
    s_ack = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("fetch_ack_single", m0_ack, 1'b0);
    cycle();
    chk("fetch_release", gnt, 2'b00);

    // 3: contention, M1 store wins, direct hand-over to M0
    set_m0(1'b1, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'hF);
    set_m1(1'b1, 1'b1, 1'b1, 32'h8040_0000, 32'hDEAD_BEEF, 4'hF);
    cycle();
    chk("cont_gnt_m1", gnt, 2'b10);
    chk("cont_sadr", s_adr, 32'h8040_0000);
    chk("cont_sdat", s_wdat, 32'hDEAD_BEEF);
    chk("cont_swe", s_we, 1'b1);
    s_ack = 1'b1;
    cycle();
    s_ack = 1'b0;
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    chk("cont_handover", gnt, 2'b01);
    s_ack = 1'b1;
    cycle();
    s_ack = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();

    // 4: M1 multi-beat with an STB gap while M0 waits
    set_m0(1'b1, 1'b1, 1'b0, 32'h8000_0200, 32'h0, 4'hF);
    set_m1(1'b1, 1'b1, 1'b0, 32'h8040_0010, 32'h0, 4'hF);
    cycle();
    chk("held_gnt0", gnt, 2'b10);
    s_ack = 1'b1; cycle();
    s_ack = 1'b0; m1_stb = 1'b0; cycle();
    chk("held_gap_gnt", gnt, 2'b10);
    s_ack = 1'b1; m1_stb = 1'b1; m1_adr = 32'h8040_0014; cycle();
    chk("held_beat2_gnt", gnt, 2'b10);
    s_ack = 1'b0;
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    chk("held_release", gnt, 2'b01);
    s_ack = 1'b1; cycle();
    s_ack = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();

    // 5: reset lands while M0 owns the bus and the slave acks
    set_m0(1'b1, 1'b1, 1'b0, 32'h8000_0300, 32'h0, 4'hF);
    cycle();
    chk("mrst_pre_gnt", gnt, 2'b01);
    reset = 1'b0; s_ack = 1'b1;
    cycle();
    reset = 1'b1;
    #1;
    chk("mrst_gnt", gnt, 2'b00);
    chk("mrst_scyc", s_cyc, 1'b0);
    chk("mrst_m0ack", m0_ack, 1'b0);
    cycle();
    s_ack = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    cycle();

    // 6: repeated simultaneous requests, arbitration policy visible in the grant order
    reset = 1'b0; cycle(); reset = 1'b1;
    for (int r = 0; r < 4; r++) begin
      set_m0(1'b1, 1'b0, 1'b0, 32'h8000_1000, 32'h0, 4'hF);
      set_m1(1'b1, 1'b0, 1'b1, 32'h8040_1000, 32'h1234_5678, 4'hF);
      cycle();
`ifdef WB_ARB_RR_EN
      chk("policy_gnt", gnt, (r % 2 == 0) ? 2'b10 : 2'b01);
`else
      chk("policy_gnt", gnt, 2'b10);
`endif
      m0_stb = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
      cycle();
      s_ack = 1'b0;
      set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      cycle();
    end

    // Random traffic against the model, with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 3) == 0) m1_cyc = ~m1_cyc;
      m0_stb = m0_cyc & $urandom_range(0, 1);
      m1_stb = m1_cyc & $urandom_range(0, 1);
      m0_we = $urandom_range(0, 1); m1_we = $urandom_range(0, 1);
      m0_adr = $urandom; m1_adr = $urandom;
      m0_wdat = $urandom; m1_wdat = $urandom;
      m0_sel = 4'($urandom); m1_sel = 4'($urandom);
      s_ack = $urandom_range(0, 1);
      s_rdat = $urandom;
      reset = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
